// File: rtl/axis_1553_pkg.sv
// Shared tuser field positions, frame geometry and FSM states for the
// MIL-STD-1553 Manchester II word encoder.
package axis_1553_pkg;

    localparam int TU_CMD      = 0;
    localparam int TU_PERR     = 1;
    localparam int TU_SWAP     = 2;
    localparam int TU_MVIOL    = 3;
    localparam int TU_IDX_LO   = 4;
    localparam int TU_IDX_HI   = 7;

    localparam int SYNC_SLOTS  = 6;
    localparam int FRAME_SLOTS = 40;
    localparam int DATA_BITS   = 16;
    localparam int PARITY_SLOT = FRAME_SLOTS - 2;

    typedef enum logic [1:0] {IDLE, WORD, GAP} state_t;

endpackage

// File: rtl/enc_1553_frame.sv
// Combinational builder of the 40 half-bit slot pattern for one 1553 word.
// Bit i of pattern is slot i; 1 means the positive leg is driven.
module enc_1553_frame
    import axis_1553_pkg::*;
(
    input  logic [15:0]            tdata,
    input  logic [7:0]             tuser,
    output logic [FRAME_SLOTS-1:0] pattern
);

    logic sync_first;
    logic bit_val;
    logic parity;

    always_comb begin
        pattern    = '0;
        bit_val    = 1'b0;
        sync_first = tuser[TU_CMD] ^ tuser[TU_SWAP];
        parity     = ~^tdata ^ tuser[TU_PERR];

        for (int s = 0; s < SYNC_SLOTS; s++)
            pattern[s] = (s < SYNC_SLOTS / 2) ? sync_first : ~sync_first;

        // A violated bit repeats its first half instead of transitioning mid-bit.
        for (int j = 0; j < DATA_BITS; j++) begin
            bit_val = tdata[DATA_BITS-1-j];
            pattern[SYNC_SLOTS + 2*j]     = bit_val;
            pattern[SYNC_SLOTS + 2*j + 1] =
                (tuser[TU_MVIOL] && (tuser[TU_IDX_HI:TU_IDX_LO] == 4'(j))) ? bit_val : ~bit_val;
        end

        pattern[PARITY_SLOT]     = parity;
        pattern[PARITY_SLOT + 1] = ~parity;
    end

endmodule

// File: rtl/axis_1553_word_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II word transmitter: owns the
// handshake, the half-bit/slot counters and the inter-message gap.
module axis_1553_word_encoder
    import axis_1553_pkg::*;
#(
    parameter int CLOCK_SPEED = 100000000,
    parameter int BIT_RATE    = 1000000,
    parameter int GAP_BITS    = 4
)
(
    input  logic        aclk,
    input  logic        arst,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic [7:0]  s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [1:0]  diff,
    output logic        busy,
    output logic        underrun
);

    localparam int CYC_BIT = CLOCK_SPEED / BIT_RATE;
    localparam int HALF    = CYC_BIT / 2;
    localparam int HCW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GAP_CYC = GAP_BITS * CYC_BIT;
    localparam int GCW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
    localparam logic [5:0]     SLOT_LAST = 6'(FRAME_SLOTS - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    if ((CYC_BIT < 2) || (CYC_BIT % 2 != 0)) begin : g_bad_rate
        $error("axis_1553_word_encoder: CLOCK_SPEED/BIT_RATE must be even and >= 2");
    end

    state_t                 state, state_nxt;
    logic [HCW-1:0]         half_cnt, half_nxt;
    logic [5:0]             slot_cnt, slot_nxt;
    logic [GCW-1:0]         gap_cnt, gap_nxt;
    logic [FRAME_SLOTS-1:0] pat_q, pat_nxt, frame_pat;
    logic                   tlast_q, tlast_nxt;
    logic                   ready_en;
    logic                   word_end;

    enc_1553_frame u_frame (
        .tdata   (s_axis_tdata),
        .tuser   (s_axis_tuser),
        .pattern (frame_pat)
    );

    // ready_en holds tready low for the first cycle after reset.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state    <= IDLE;
            half_cnt <= '0;
            slot_cnt <= '0;
            gap_cnt  <= '0;
            pat_q    <= '0;
            tlast_q  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            half_cnt <= half_nxt;
            slot_cnt <= slot_nxt;
            gap_cnt  <= gap_nxt;
            pat_q    <= pat_nxt;
            tlast_q  <= tlast_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        half_nxt      = half_cnt;
        slot_nxt      = slot_cnt;
        gap_nxt       = gap_cnt;
        pat_nxt       = pat_q;
        tlast_nxt     = tlast_q;
        s_axis_tready = 1'b0;
        underrun      = 1'b0;
        word_end      = (half_cnt == HALF_LAST) && (slot_cnt == SLOT_LAST);

        case (state)
            IDLE: s_axis_tready = ready_en;
            WORD: begin
                if (half_cnt == HALF_LAST) begin
                    half_nxt = '0;
                    slot_nxt = slot_cnt + 6'd1;
                end else begin
                    half_nxt = half_cnt + HCW'(1);
                end
                if (word_end) begin
                    slot_nxt = '0;
                    if (!tlast_q) s_axis_tready = 1'b1;
                    if (tlast_q || !s_axis_tvalid) begin
                        underrun  = ~tlast_q;
                        gap_nxt   = '0;
                        state_nxt = (GAP_BITS == 0) ? IDLE : GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GCW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Loading here lets a chained word start with no idle cycle.
        if (s_axis_tvalid && s_axis_tready) begin
            pat_nxt   = frame_pat;
            tlast_nxt = s_axis_tlast;
            half_nxt  = '0;
            slot_nxt  = '0;
            state_nxt = WORD;
        end
    end

    assign diff = (state == WORD) ? {~pat_q[slot_cnt], pat_q[slot_cnt]} : 2'b00;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_axis_1553_word_encoder.sv
// Self-checking bench for axis_1553_word_encoder at the default rate and at
// a one-cycle half-bit rate with no inter-message gap.
module tb_axis_1553_word_encoder;

    localparam int HALF     = 50;
    localparam int WORD_CYC = 40 * HALF;
    localparam int GAP_CYC  = 4 * 2 * HALF;

    logic tb_data_clk = 1'b0;
    always #5 tb_data_clk = ~tb_data_clk;

    logic        arst = 1'b1;
    logic [15:0] tdata = '0;
    logic [7:0]  tuser = '0;
    logic        tvalid = 1'b0, tlast = 1'b0;
    logic        tready, busy, underrun;
    logic [1:0]  diff;

    logic [15:0] f_tdata = '0;
    logic [7:0]  f_tuser = '0;
    logic        f_tvalid = 1'b0, f_tlast = 1'b0;
    logic        f_tready, f_busy, f_underrun;
    logic [1:0]  f_diff;

    int errors = 0;
    int checks = 0;

    axis_1553_word_encoder #(.CLOCK_SPEED(100000000), .BIT_RATE(1000000), .GAP_BITS(4)) dut (
        .aclk(tb_data_clk), .arst(arst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tuser(tuser),
        .s_axis_tlast(tlast), .s_axis_tready(tready),
        .diff(diff), .busy(busy), .underrun(underrun)
    );

    axis_1553_word_encoder #(.CLOCK_SPEED(2000000), .BIT_RATE(1000000), .GAP_BITS(0)) dut_fast (
        .aclk(tb_data_clk), .arst(arst),
        .s_axis_tdata(f_tdata), .s_axis_tvalid(f_tvalid), .s_axis_tuser(f_tuser),
        .s_axis_tlast(f_tlast), .s_axis_tready(f_tready),
        .diff(f_diff), .busy(f_busy), .underrun(f_underrun)
    );

    // Expected bus level for cycle t of a word, straight from the frame rules.
    function automatic logic [1:0] exp_diff(input logic [15:0] d, input logic [7:0] u,
                                            input int t, input int half);
        int   slot, j;
        logic level, b, p, first;
        slot  = t / half;
        level = 1'b0;
        if (slot < 6) begin
            first = u[0] ^ u[2];
            level = (slot < 3) ? first : ~first;
        end else if (slot < 38) begin
            j = (slot - 6) / 2;
            b = d[15-j];
            if ((slot - 6) % 2 == 0)                     level = b;
            else if (u[3] && (int'(u[7:4]) == j))        level = b;
            else                                         level = ~b;
        end else begin
            p     = ~^d ^ u[1];
            level = (slot == 38) ? p : ~p;
        end
        return level ? 2'b01 : 2'b10;
    endfunction

    task automatic next_cycle();
        @(posedge tb_data_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) next_cycle();
        @(negedge tb_data_clk);
        checks++;
        if (diff !== 2'b00 || busy !== 1'b0 || tready !== 1'b0 || underrun !== 1'b0 ||
            f_diff !== 2'b00 || f_busy !== 1'b0 || f_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values got diff=%b busy=%b tready=%b underrun=%b f_diff=%b f_busy=%b f_tready=%b want 00/0/0/0/00/0/0",
                     diff, busy, tready, underrun, f_diff, f_busy, f_tready);
        end
        next_cycle();
        arst = 1'b0;
        @(negedge tb_data_clk);
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_cycle_ready got tready=%b want 0", tready);
        end
        next_cycle();
        @(negedge tb_data_clk);
        checks++;
        if (tready !== 1'b1 || busy !== 1'b0 || diff !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got tready=%b busy=%b diff=%b want 1/0/00", tready, busy, diff);
        end
    endtask

    task automatic test_single_word();
        logic [15:0] d;
        logic [7:0]  u;
        for (int m = 0; m < 3; m++) begin
            d = (m == 0) ? 16'hA5A5 : 16'($urandom);
            u = (m == 0) ? 8'h01 : 8'($urandom);
            next_cycle();
            tdata = d; tuser = u; tlast = 1'b1; tvalid = 1'b1;
            @(negedge tb_data_clk);
            checks++;
            if (tready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_accept got tready=%b busy=%b want 1/0", tready, busy);
            end
            for (int t = 0; t < WORD_CYC + GAP_CYC; t++) begin
                next_cycle();
                tvalid = 1'b0; tdata = 16'($urandom); tuser = 8'($urandom);
                @(negedge tb_data_clk);
                checks++;
                if (diff !== ((t < WORD_CYC) ? exp_diff(d, u, t, HALF) : 2'b00) ||
                    tready !== 1'b0 || busy !== 1'b1 || underrun !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL single_word t=%0d got diff=%b tready=%b busy=%b underrun=%b want diff=%b 0/1/0",
                             t, diff, tready, busy, underrun, (t < WORD_CYC) ? exp_diff(d, u, t, HALF) : 2'b00);
                end
            end
        end
    endtask

    task automatic test_error_injection();
        logic [7:0] users[3] = '{8'h32, 8'h38, 8'h04};
        for (int m = 0; m < 3; m++) begin
            next_cycle();
            tdata = 16'hFFFF; tuser = users[m]; tlast = 1'b1; tvalid = 1'b1;
            @(negedge tb_data_clk);
            checks++;
            if (tready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL inject_accept tuser=%h got tready=%b want 1", users[m], tready);
            end
            for (int t = 0; t < WORD_CYC + GAP_CYC; t++) begin
                next_cycle();
                tvalid = 1'b0;
                @(negedge tb_data_clk);
                checks++;
                if (diff !== ((t < WORD_CYC) ? exp_diff(16'hFFFF, users[m], t, HALF) : 2'b00) || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL inject tuser=%h t=%0d got diff=%b busy=%b want diff=%b busy=1", users[m], t, diff,
                             busy, (t < WORD_CYC) ? exp_diff(16'hFFFF, users[m], t, HALF) : 2'b00);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[4];
        logic [7:0]  users[4];
        logic [1:0]  exp;
        logic        exp_rdy;
        int          n;
        for (int m = 0; m < 3; m++) begin
            if (m == 0) begin
                n = 3;
                words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h1234;
                users[0] = 8'h00;    users[1] = 8'h00;    users[2] = 8'h00;
            end else begin
                n = int'($urandom_range(2, 4));
                for (int i = 0; i < n; i++) begin
                    words[i] = 16'($urandom);
                    users[i] = 8'($urandom);
                end
            end
            next_cycle();
            tdata = words[0]; tuser = users[0]; tlast = (n == 1); tvalid = 1'b1;
            @(negedge tb_data_clk);
            checks++;
            if (tready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL chain_accept got tready=%b busy=%b want 1/0", tready, busy);
            end
            for (int w = 0; w < n; w++) begin
                for (int t = 0; t < WORD_CYC; t++) begin
                    next_cycle();
                    if (w + 1 < n) begin
                        tvalid = 1'b1; tdata = words[w+1]; tuser = users[w+1]; tlast = (w + 2 == n);
                    end else begin
                        tvalid = 1'b0; tdata = 16'($urandom); tuser = 8'($urandom); tlast = 1'($urandom);
                    end
                    @(negedge tb_data_clk);
                    exp     = exp_diff(words[w], users[w], t, HALF);
                    exp_rdy = (t == WORD_CYC - 1) && (w + 1 < n);
                    checks++;
                    if (diff !== exp || tready !== exp_rdy || busy !== 1'b1 || underrun !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL chain word=%0d t=%0d got diff=%b tready=%b busy=%b underrun=%b want diff=%b tready=%b 1/0",
                                 w, t, diff, tready, busy, underrun, exp, exp_rdy);
                    end
                end
            end
            for (int g = 0; g < GAP_CYC; g++) begin
                next_cycle();
                tvalid = 1'b0;
                @(negedge tb_data_clk);
                checks++;
                if (diff !== 2'b00 || tready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL chain_gap g=%0d got diff=%b tready=%b busy=%b want 00/0/1", g, diff, tready, busy);
                end
            end
        end
    endtask

    task automatic test_underrun();
        logic [15:0] d;
        logic [7:0]  u;
        logic        last;
        d = 16'($urandom);
        u = 8'($urandom);
        next_cycle();
        tdata = d; tuser = u; tlast = 1'b0; tvalid = 1'b1;
        @(negedge tb_data_clk);
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_accept got tready=%b want 1", tready);
        end
        for (int t = 0; t < WORD_CYC + GAP_CYC; t++) begin
            next_cycle();
            tvalid = 1'b0;
            @(negedge tb_data_clk);
            last = (t == WORD_CYC - 1);
            checks++;
            if (diff !== ((t < WORD_CYC) ? exp_diff(d, u, t, HALF) : 2'b00) ||
                underrun !== last || tready !== last || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL underrun t=%0d got diff=%b underrun=%b tready=%b busy=%b want diff=%b underrun=%b tready=%b busy=1",
                         t, diff, underrun, tready, busy, (t < WORD_CYC) ? exp_diff(d, u, t, HALF) : 2'b00, last, last);
            end
        end
        next_cycle();
        @(negedge tb_data_clk);
        checks++;
        if (tready !== 1'b1 || busy !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_idle got tready=%b busy=%b underrun=%b want 1/0/0", tready, busy, underrun);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] d;
        logic [7:0]  u;
        d = 16'($urandom);
        u = 8'($urandom);
        next_cycle();
        tdata = d; tuser = u; tlast = 1'b1; tvalid = 1'b1;
        for (int t = 0; t < 700; t++) begin
            next_cycle();
            tvalid = 1'b0;
            @(negedge tb_data_clk);
            checks++;
            if (diff !== exp_diff(d, u, t, HALF)) begin
                errors++;
                $display("[TB] FAIL pre_reset t=%0d got diff=%b want %b", t, diff, exp_diff(d, u, t, HALF));
            end
        end
        next_cycle();
        arst = 1'b1;
        next_cycle();
        arst = 1'b0;
        @(negedge tb_data_clk);
        checks++;
        if (diff !== 2'b00 || busy !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_word_reset got diff=%b busy=%b tready=%b want 00/0/0", diff, busy, tready);
        end
        d = 16'($urandom);
        u = 8'($urandom);
        next_cycle();
        tdata = d; tuser = u; tlast = 1'b1; tvalid = 1'b1;
        @(negedge tb_data_clk);
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_accept got tready=%b want 1", tready);
        end
        for (int t = 0; t < WORD_CYC + GAP_CYC; t++) begin
            next_cycle();
            tvalid = 1'b0;
            @(negedge tb_data_clk);
            checks++;
            if (diff !== ((t < WORD_CYC) ? exp_diff(d, u, t, HALF) : 2'b00) || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL post_reset_word t=%0d got diff=%b busy=%b want diff=%b busy=1", t, diff, busy,
                         (t < WORD_CYC) ? exp_diff(d, u, t, HALF) : 2'b00);
            end
        end
    endtask

    task automatic test_fast_rate();
        logic [15:0] words[3];
        logic [7:0]  users[3];
        logic        exp_rdy;
        int          n;
        for (int m = 0; m < 4; m++) begin
            n = (m == 0) ? 1 : int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                words[i] = 16'($urandom);
                users[i] = 8'($urandom);
            end
            next_cycle();
            f_tdata = words[0]; f_tuser = users[0]; f_tlast = (n == 1); f_tvalid = 1'b1;
            @(negedge tb_data_clk);
            checks++;
            if (f_tready !== 1'b1 || f_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fast_accept got tready=%b busy=%b want 1/0", f_tready, f_busy);
            end
            for (int w = 0; w < n; w++) begin
                for (int t = 0; t < 40; t++) begin
                    next_cycle();
                    if (w + 1 < n) begin
                        f_tvalid = 1'b1; f_tdata = words[w+1]; f_tuser = users[w+1]; f_tlast = (w + 2 == n);
                    end else begin
                        f_tvalid = 1'b0;
                    end
                    @(negedge tb_data_clk);
                    exp_rdy = (t == 39) && (w + 1 < n);
                    checks++;
                    if (f_diff !== exp_diff(words[w], users[w], t, 1) || f_tready !== exp_rdy ||
                        f_busy !== 1'b1 || f_underrun !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL fast word=%0d t=%0d got diff=%b tready=%b busy=%b underrun=%b want diff=%b tready=%b 1/0",
                                 w, t, f_diff, f_tready, f_busy, f_underrun, exp_diff(words[w], users[w], t, 1), exp_rdy);
                    end
                end
            end
            next_cycle();
            f_tvalid = 1'b0;
            @(negedge tb_data_clk);
            checks++;
            if (f_tready !== 1'b1 || f_busy !== 1'b0 || f_diff !== 2'b00) begin
                errors++;
                $display("[TB] FAIL fast_idle_after_last got tready=%b busy=%b diff=%b want 1/0/00", f_tready, f_busy, f_diff);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single_word();
        test_error_injection();
        test_back_to_back();
        test_underrun();
        test_reset_mid_word();
        test_fast_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_1553_word_encoder.md
Name: axis_1553_word_encoder

Overview:
- Synthesizable MIL-STD-1553 Manchester II word transmitter.
- Takes 16-bit words on an AXI-Stream slave. For each word it generates the sync, data and odd parity, and drives the differential pair.
- Words chain back-to-back within a message (tlast delimits) with a parametrised inter-message gap.
- Per-word error injection on tuser gives a reusable traffic source for decoder benches and a TX path for the terminal design.

Parameters:
- CLOCK_SPEED, 100000000, aclk frequency in Hz.
- BIT_RATE, 1000000, bus bit rate in Hz. CYC_BIT = CLOCK_SPEED/BIT_RATE must be even and >=2; elaboration error otherwise. HALF = CYC_BIT/2.
- GAP_BITS, 4, idle bit times inserted after a tlast word (0 allowed).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- arst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  16  data word, MSB transmitted first.
- s_axis_tvalid  in  1  word valid.
- s_axis_tuser  in  8  control (see Behaviour).
- s_axis_tlast  in  1  last word of message.
- s_axis_tready  out  1  word accept.
- diff  out  2  diff[0] positive leg, diff[1] negative leg.
- busy  out  1  high while in SYNC/WORD/GAP.
- underrun  out  1  one-cycle pulse on chain underflow.

Behaviour:
Reset:
- Values: diff=2'b00, s_axis_tready=0, busy=0, underrun=0, state=IDLE, counters=0.
- arst wins over everything. A word in flight is dropped and diff returns to 00 on the next cycle, with no partial tail.

tuser fields:
- [0]: 1 = command/status sync, 0 = data sync.
- [1]: invert parity (error injection).
- [2]: swap the sync polarity.
- [3]: enable Manchester violation.
- [7:4]: data bit index k (0 = MSB) for the violation.

Frame:
- 40 half-bit slots, each HALF cycles long.
- Slots 0-5, command sync: 3 positive then 3 negative. Data sync is the opposite. tuser[2] swaps them.
- Slots 6-37: data bits. Logic 1 = positive then negative; logic 0 = negative then positive.
- Slots 38-39: parity P = ~^tdata (odd), XOR tuser[1].
- Violation: data bit k drives both halves at its logic level (1 -> +,+ and 0 -> -,-).
- Outside IDLE/GAP, diff[1] = ~diff[0]. In IDLE/GAP, diff = 00.

FSM states:
- IDLE:
  - tready=1.
  - On tvalid&tready, latch a 40-slot pattern plus tlast, then go to WORD.
  - diff shows slot 0 on the cycle after acceptance (latency 1).
- WORD:
  - A half-bit counter steps 0..HALF-1; a slot counter steps 0..39. Each word occupies exactly 40*HALF cycles.
  - In the final cycle of slot 39, if the latched tlast=0, tready=1 for that single cycle.
    - If tvalid: load the next word; slot 0 follows with no gap and no idle cycle.
    - If no tvalid: pulse underrun and go to GAP, treating the message as ended.
  - In the final cycle with tlast=1, go to GAP (or to IDLE if GAP_BITS=0).
- GAP:
  - Holds diff=00 for GAP_BITS*CYC_BIT cycles, with tready=0.
  - Then goes to IDLE.

Other rules:
- tready is never high in SYNC-slot or mid-word cycles.
- tdata and tuser are only sampled on the handshake; later changes are ignored.
- Counters are sized $clog2(HALF) and 6 bits; no wrap beyond 39.

Decomposition:
- Package axis_1553_pkg contains:
  - tuser field positions: TU_CMD=0, TU_PERR=1, TU_SWAP=2, TU_MVIOL=3, TU_IDX=7:4.
  - SYNC_SLOTS=6, FRAME_SLOTS=40.
  - The state enum {IDLE, WORD, GAP}.
- Sub-module enc_1553_frame (combinational): tdata+tuser -> 40-bit slot pattern. The top module owns the FSM, counters and handshake.

Test Plan:
Defaults (HALF=50, word=2000 cycles) unless stated.
- Single word 16'hA5A5, tuser=8'h01, tlast=1:
  - Sync is 150 cycles diff=01 then 150 cycles diff=10.
  - Parity slot = 1 (P = ~^16'hA5A5 = 1).
  - Then 400 cycles diff=00, then tready=1.
- Three words 16'h0000/16'hFFFF/16'h1234 with tuser=8'h00, tlast only on the last word:
  - 6000 contiguous cycles with no 00 cycle.
  - tready high exactly in cycles 1999 and 3999 after the first accept.
- Two-word message with the second tvalid withheld:
  - underrun pulses once at cycle 1999.
  - diff=00 for 400 cycles, then IDLE.
- Error injection on 16'hFFFF:
  - tuser=8'h32 (perr, k=3): parity slot inverted.
  - tuser=8'h38 (violation, k=3): data bit 3 is 100 cycles diff=01.
  - tuser=8'h04 (swap): data-sync word shows the command sync.
- arst asserted at cycle 700 of a word: diff=00, busy=0, tready=0 next cycle. After release, a new word transmits correctly from slot 0.
- CLOCK_SPEED=2000000 (HALF=1), GAP_BITS=0:
  - 40-cycle word.
  - tready high in IDLE on the cycle after tlast completes.
